// File: rtl/wb_writer.sv
// Register file write-port arbiter: merges ALU and load-return writebacks
// and tracks pending loads for decode-stage operand stalls.
module wb_writer #(
    parameter int NUM_REG    = 6,
    parameter int BITS       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_wen_i,
    input  logic [NUM_REG-1:0] alu_wa_i,
    input  logic [BITS-1:0]    alu_wd_i,
    input  logic               ld_issue_i,
    input  logic [NUM_REG-1:0] ld_issue_wa_i,
    input  logic               ld_valid_i,
    input  logic [NUM_REG-1:0] ld_wa_i,
    input  logic [BITS-1:0]    ld_wd_i,
    output logic               ld_ready_o,
    input  logic [NUM_REG-1:0] ra0_i,
    input  logic [NUM_REG-1:0] ra1_i,
    output logic               busy0_o,
    output logic               busy1_o,
    output logic               wen_o,
    output logic [NUM_REG-1:0] wa_o,
    output logic [BITS-1:0]    wd_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 2 ** NUM_REG;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [NUM_REG-1:0] fifo_wa [FIFO_DEPTH];
    logic [BITS-1:0]    fifo_wd [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic [NR-1:0]      pending;
    logic [NR-1:0]      pending_nxt;

    logic accept;
    logic fifo_ne;
    logic sel_alu;
    logic sel_pop;
    logic sel_byp;
    logic push;
    logic clr_en;
    logic [NUM_REG-1:0] clr_wa;

    assign ld_ready_o = (count != FULL);
    assign accept     = ld_valid_i & ld_ready_o;
    assign fifo_ne    = (count != '0);
    assign sel_alu    = alu_wen_i;
    assign sel_pop    = !alu_wen_i & fifo_ne;
    assign sel_byp    = !alu_wen_i & !fifo_ne & accept;
    assign push       = accept & !sel_byp;
    assign busy0_o    = pending[ra0_i];
    assign busy1_o    = pending[ra1_i];

    always_comb begin
        clr_en = sel_pop | sel_byp;
        clr_wa = sel_pop ? fifo_wa[rd_ptr] : ld_wa_i;
        pending_nxt = pending;
        if (clr_en) pending_nxt[clr_wa] = 1'b0;
        // A new issue to the register being retired must stay pending.
        if (ld_issue_i) pending_nxt[ld_issue_wa_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa[wr_ptr] <= ld_wa_i;
            fifo_wd[wr_ptr] <= ld_wd_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pending <= '0;
        end else begin
            pending <= pending_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (sel_pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, sel_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_o <= 1'b0;
            wa_o  <= '0;
            wd_o  <= '0;
        end else begin
            unique case (1'b1)
                sel_alu: begin
                    wen_o <= 1'b1;
                    wa_o  <= alu_wa_i;
                    wd_o  <= alu_wd_i;
                end
                sel_pop: begin
                    wen_o <= 1'b1;
                    wa_o  <= fifo_wa[rd_ptr];
                    wd_o  <= fifo_wd[rd_ptr];
                end
                sel_byp: begin
                    wen_o <= 1'b1;
                    wa_o  <= ld_wa_i;
                    wd_o  <= ld_wd_i;
                end
                default: wen_o <= 1'b0;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_issue_free: assert property (@(posedge clk) disable iff (!rst_n)
        ld_issue_i |-> (!pending[ld_issue_wa_i] ||
                        (clr_en && clr_wa == ld_issue_wa_i)));
    a_alu_free: assert property (@(posedge clk) disable iff (!rst_n)
        alu_wen_i |-> !pending[alu_wa_i]);
    a_ld_pending: assert property (@(posedge clk) disable iff (!rst_n)
        ld_valid_i |-> pending[ld_wa_i]);
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Directed self-checking bench for wb_writer.
// Each task drives one scenario and checks its own hand-computed results.
module tb_wb_writer;

    localparam int NUM_REG    = 6;
    localparam int BITS       = 32;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               alu_wen_i;
    logic [NUM_REG-1:0] alu_wa_i;
    logic [BITS-1:0]    alu_wd_i;
    logic               ld_issue_i;
    logic [NUM_REG-1:0] ld_issue_wa_i;
    logic               ld_valid_i;
    logic [NUM_REG-1:0] ld_wa_i;
    logic [BITS-1:0]    ld_wd_i;
    logic               ld_ready_o;
    logic [NUM_REG-1:0] ra0_i;
    logic [NUM_REG-1:0] ra1_i;
    logic               busy0_o;
    logic               busy1_o;
    logic               wen_o;
    logic [NUM_REG-1:0] wa_o;
    logic [BITS-1:0]    wd_o;

    int total = 0;
    int bad   = 0;

    wb_writer #(
        .NUM_REG(NUM_REG), .BITS(BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wen_i(alu_wen_i), .alu_wa_i(alu_wa_i), .alu_wd_i(alu_wd_i),
        .ld_issue_i(ld_issue_i), .ld_issue_wa_i(ld_issue_wa_i),
        .ld_valid_i(ld_valid_i), .ld_wa_i(ld_wa_i), .ld_wd_i(ld_wd_i),
        .ld_ready_o(ld_ready_o),
        .ra0_i(ra0_i), .ra1_i(ra1_i),
        .busy0_o(busy0_o), .busy1_o(busy1_o),
        .wen_o(wen_o), .wa_o(wa_o), .wd_o(wd_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_wen_i = 0; alu_wa_i = '0; alu_wd_i = '0;
        ld_issue_i = 0; ld_issue_wa_i = '0;
        ld_valid_i = 0; ld_wa_i = '0; ld_wd_i = '0;
        ra0_i = '0; ra1_i = '0;
    endtask

    task automatic issue(input int r);
        ld_issue_i = 1; ld_issue_wa_i = 6'(r);
        tick();
        ld_issue_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #12;
        total += 6;
        if (wen_o !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", wen_o); end
        if (wa_o !== '0) begin bad++; $display("FAIL reset_wa got=%0d exp=0", wa_o); end
        if (wd_o !== '0) begin bad++; $display("FAIL reset_wd got=%h exp=0", wd_o); end
        if (ld_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ld_ready_o); end
        if (busy0_o !== 1'b0) begin bad++; $display("FAIL reset_busy0 got=%b exp=0", busy0_o); end
        if (busy1_o !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b exp=0", busy1_o); end
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_alu();
        alu_wen_i = 1; alu_wa_i = 5; alu_wd_i = 32'h11;
        tick();
        alu_wen_i = 0;
        total += 3;
        if (wen_o !== 1'b1) begin bad++; $display("FAIL alu_wen got=%b exp=1", wen_o); end
        if (wa_o !== 6'd5) begin bad++; $display("FAIL alu_wa got=%0d exp=5", wa_o); end
        if (wd_o !== 32'h11) begin bad++; $display("FAIL alu_wd got=%h exp=11", wd_o); end
        tick();
        total += 2;
        if (wen_o !== 1'b0) begin bad++; $display("FAIL alu_idle_wen got=%b exp=0", wen_o); end
        if (wa_o !== 6'd5) begin bad++; $display("FAIL alu_hold_wa got=%0d exp=5", wa_o); end
    endtask

    task automatic test_load_bypass();
        issue(3);
        ra0_i = 3;
        #1;
        total += 2;
        if (busy0_o !== 1'b1) begin bad++; $display("FAIL byp_busy_pre got=%b exp=1", busy0_o); end
        if (ld_ready_o !== 1'b1) begin bad++; $display("FAIL byp_ready got=%b exp=1", ld_ready_o); end
        ld_valid_i = 1; ld_wa_i = 3; ld_wd_i = 32'hAB;
        tick();
        ld_valid_i = 0;
        #1;
        total += 4;
        if (wen_o !== 1'b1) begin bad++; $display("FAIL byp_wen got=%b exp=1", wen_o); end
        if (wa_o !== 6'd3) begin bad++; $display("FAIL byp_wa got=%0d exp=3", wa_o); end
        if (wd_o !== 32'hAB) begin bad++; $display("FAIL byp_wd got=%h exp=ab", wd_o); end
        if (busy0_o !== 1'b0) begin bad++; $display("FAIL byp_busy_post got=%b exp=0", busy0_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lw[5] = '{2, 4, 6, 7, 8};
        int idx = 0;
        bit acc;
        for (int i = 0; i < 5; i++) issue(lw[i]);
        for (int i = 0; i < 6; i++) begin
            alu_wen_i = 1; alu_wa_i = 1; alu_wd_i = 32'h50 + 32'(i);
            ld_valid_i = (idx < 5);
            if (idx < 5) begin ld_wa_i = 6'(lw[idx]); ld_wd_i = 32'h100 + 32'(lw[idx]); end
            #1;
            total++;
            if (ld_ready_o !== (i < 4)) begin
                bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, ld_ready_o, (i < 4));
            end
            acc = ld_valid_i && ld_ready_o;
            tick();
            if (acc) idx++;
            total += 2;
            if (wen_o !== 1'b1 || wa_o !== 6'd1) begin
                bad++; $display("FAIL b2b_alu_wa[%0d] got=%b/%0d exp=1/1", i, wen_o, wa_o);
            end
            if (wd_o !== 32'h50 + 32'(i)) begin
                bad++; $display("FAIL b2b_alu_wd[%0d] got=%h exp=%h", i, wd_o, 32'h50 + 32'(i));
            end
        end
        alu_wen_i = 0;
        total++;
        if (idx !== 4) begin bad++; $display("FAIL b2b_buffered got=%0d exp=4", idx); end
        for (int j = 0; j < 5; j++) begin
            ld_valid_i = (idx < 5);
            if (idx < 5) begin ld_wa_i = 6'(lw[idx]); ld_wd_i = 32'h100 + 32'(lw[idx]); end
            #1;
            acc = ld_valid_i && ld_ready_o;
            tick();
            if (acc) idx++;
            total += 2;
            if (wen_o !== 1'b1 || wa_o !== 6'(lw[j])) begin
                bad++; $display("FAIL b2b_ld_wa[%0d] got=%b/%0d exp=1/%0d", j, wen_o, wa_o, lw[j]);
            end
            if (wd_o !== 32'h100 + 32'(lw[j])) begin
                bad++; $display("FAIL b2b_ld_wd[%0d] got=%h exp=%h", j, wd_o, 32'h100 + 32'(lw[j]));
            end
        end
        ld_valid_i = 0;
        tick();
        ra0_i = 8;
        #1;
        total += 2;
        if (wen_o !== 1'b0) begin bad++; $display("FAIL b2b_drain_wen got=%b exp=0", wen_o); end
        if (busy0_o !== 1'b0) begin bad++; $display("FAIL b2b_busy8 got=%b exp=0", busy0_o); end
    endtask

    task automatic test_full_drain();
        int exp_q[$];
        int nxt = 14;
        int writes = 0;
        bit acc;
        for (int r = 10; r <= 15; r++) issue(r);
        for (int i = 0; i < 4; i++) begin
            alu_wen_i = 1; alu_wa_i = 1; alu_wd_i = 32'(i);
            ld_valid_i = 1; ld_wa_i = 6'(10 + i); ld_wd_i = 32'h200 + 32'(10 + i);
            tick();
            exp_q.push_back(10 + i);
        end
        alu_wen_i = 0;
        for (int c = 0; c < 16; c++) begin
            ld_valid_i = (nxt <= 15);
            ld_wa_i = 6'(nxt); ld_wd_i = 32'h200 + 32'(nxt);
            #1;
            if (c == 0) begin
                total++;
                if (ld_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready0 got=%b exp=0", ld_ready_o); end
            end
            if (c == 1) begin
                total++;
                if (ld_ready_o !== 1'b1) begin bad++; $display("FAIL full_ready1 got=%b exp=1", ld_ready_o); end
            end
            acc = ld_valid_i && ld_ready_o;
            tick();
            if (acc) begin exp_q.push_back(nxt); nxt++; end
            if (wen_o === 1'b1) begin
                writes++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL full_extra_write got=%0d exp=none", wa_o);
                end else if (wa_o !== 6'(exp_q[0]) || wd_o !== 32'h200 + 32'(exp_q[0])) begin
                    bad++; $display("FAIL full_order got=%0d/%h exp=%0d/%h",
                                    wa_o, wd_o, exp_q[0], 32'h200 + 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
        ld_valid_i = 0;
        ra0_i = 15; ra1_i = 14;
        #1;
        total += 4;
        if (writes !== 6) begin bad++; $display("FAIL full_writes got=%0d exp=6", writes); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL full_lost got=%0d exp=0", exp_q.size()); end
        if (ld_ready_o !== 1'b1) begin bad++; $display("FAIL full_ready_end got=%b exp=1", ld_ready_o); end
        if (busy0_o !== 1'b0 || busy1_o !== 1'b0) begin
            bad++; $display("FAIL full_busy_end got=%b%b exp=00", busy0_o, busy1_o);
        end
    endtask

    task automatic test_set_wins();
        issue(9);
        ld_valid_i = 1; ld_wa_i = 9; ld_wd_i = 32'h99;
        ld_issue_i = 1; ld_issue_wa_i = 9;
        tick();
        ld_valid_i = 0; ld_issue_i = 0;
        ra0_i = 9;
        #1;
        total += 3;
        if (wen_o !== 1'b1 || wa_o !== 6'd9) begin
            bad++; $display("FAIL setwin_write got=%b/%0d exp=1/9", wen_o, wa_o);
        end
        if (wd_o !== 32'h99) begin bad++; $display("FAIL setwin_wd got=%h exp=99", wd_o); end
        if (busy0_o !== 1'b1) begin bad++; $display("FAIL setwin_busy got=%b exp=1", busy0_o); end
        ld_valid_i = 1; ld_wa_i = 9; ld_wd_i = 32'h9A;
        tick();
        ld_valid_i = 0;
        #1;
        total++;
        if (busy0_o !== 1'b0) begin bad++; $display("FAIL setwin_clear got=%b exp=0", busy0_o); end
    endtask

    task automatic test_reset_mid();
        for (int r = 20; r <= 22; r++) issue(r);
        for (int i = 0; i < 3; i++) begin
            alu_wen_i = 1; alu_wa_i = 1; alu_wd_i = 32'h70;
            ld_valid_i = 1; ld_wa_i = 6'(20 + i); ld_wd_i = 32'h300 + 32'(i);
            tick();
        end
        ld_valid_i = 0;
        tick();
        alu_wen_i = 0;
        total++;
        if (wen_o !== 1'b1) begin bad++; $display("FAIL rmid_pre_wen got=%b exp=1", wen_o); end
        rst_n = 0;
        idle_inputs();
        ra0_i = 20; ra1_i = 21;
        #1;
        total += 4;
        if (wen_o !== 1'b0) begin bad++; $display("FAIL rmid_wen got=%b exp=0", wen_o); end
        if (ld_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", ld_ready_o); end
        if (busy0_o !== 1'b0) begin bad++; $display("FAIL rmid_busy0 got=%b exp=0", busy0_o); end
        if (busy1_o !== 1'b0) begin bad++; $display("FAIL rmid_busy1 got=%b exp=0", busy1_o); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (wen_o !== 1'b0) begin bad++; $display("FAIL rmid_stale[%0d] got=%b exp=0", i, wen_o); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_bypass();
        test_back_to_back();
        test_full_drain();
        test_set_wins();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
